// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential single-precision divider.
package fp_div_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, ITER, PACK, DONE} state_t;

    localparam int EXP_BIAS = 127;
    localparam int QBITS    = 27;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] POS_INF = 32'h7F800000;

    // Exponent field of zero covers true zeros and flushed denormals.
    function automatic logic is_zero(input logic [31:0] f);
        return f[30:23] == 8'd0;
    endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring division step: trial-subtract divisor, keep if non-negative, shift.
module fp_div_step (
    input  logic [24:0] rem,
    input  logic [23:0] divisor,
    input  logic [26:0] quo,
    output logic [24:0] rem_next,
    output logic [26:0] quo_next
);

    logic [25:0] diff;
    logic        ge;
    logic [24:0] kept;

    // kept is always below the divisor, so the left shift cannot lose a bit.
    always_comb begin
        diff     = {1'b0, rem} - {2'b00, divisor};
        ge       = ~diff[25];
        kept     = ge ? diff[24:0] : rem;
        rem_next = kept << 1;
        quo_next = (quo << 1) | {26'd0, ge};
    end

endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE-754 single-precision divider with valid/ready handshakes.
// Define FP_DIV_SEQ_ROUND_EN for round-to-nearest-even; default truncates.
module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        busy
);

    localparam int ITER_CYCLES = QBITS / BITS_PER_CYCLE;
    localparam int CW = $clog2(ITER_CYCLES + 1);
    localparam logic signed [9:0] E_MAX  = 10'(EXP_MAX);
    localparam logic signed [9:0] E_BIAS = 10'(EXP_BIAS);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 3 ||
          BITS_PER_CYCLE == 9 || BITS_PER_CYCLE == 27)) begin : g_bad_bpc
        $error("fp_div_seq: BITS_PER_CYCLE must be 1, 3, 9 or 27");
    end

    state_t state, state_next;

    logic [31:0]        a_r, b_r;
    logic               sign_r;
    logic signed [9:0]  ediff_r;
    logic [24:0]        rem_r;
    logic [23:0]        mb_r;
    logic [26:0]        quo_r;
    logic [CW-1:0]      cnt_r;
    logic               special_r;
    logic [31:0]        spec_res_r;
    logic               spec_dbz_r;

    logic               setup_special;
    logic signed [9:0]  e_norm;
    logic [22:0]        mant;
    logic [33:0]        packed_res;

    logic [24:0] rem_chain [0:BITS_PER_CYCLE];
    logic [26:0] quo_chain [0:BITS_PER_CYCLE];

    // Overflow saturates to signed infinity, underflow flushes to signed zero.
    function automatic logic [33:0] range_pack(input logic s, input logic signed [9:0] e,
                                               input logic [22:0] m);
        if (e >= E_MAX)
            return {2'b10, POS_INF | {s, 31'd0}};
        else if (e <= 10'sd0)
            return {2'b01, s, 31'd0};
        return {2'b00, s, e[7:0], m};
    endfunction

`ifdef FP_DIV_SEQ_ROUND_EN
    logic        guard, sticky;
    logic [23:0] rnd;

    function automatic logic [23:0] round_rne(input logic [22:0] m, input logic g, input logic s);
        return {1'b0, m} + {23'd0, g & (s | m[0])};
    endfunction
`endif

    assign in_ready      = (state == IDLE);
    assign busy          = (state != IDLE);
    assign out_valid     = (state == DONE);
    assign setup_special = is_zero(a_r) | is_zero(b_r);

    assign rem_chain[0] = rem_r;
    assign quo_chain[0] = quo_r;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        fp_div_step u_step (
            .rem      (rem_chain[i]),
            .divisor  (mb_r),
            .quo      (quo_chain[i]),
            .rem_next (rem_chain[i+1]),
            .quo_next (quo_chain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SETUP;
            SETUP:   state_next = setup_special ? PACK : ITER;
            ITER:    if (cnt_r == '0) state_next = PACK;
            PACK:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, unpack and iteration datapath
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_r <= a;
                    b_r <= b;
                end
            end
            SETUP: begin
                sign_r     <= a_r[31] ^ b_r[31];
                ediff_r    <= $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]});
                rem_r      <= {2'b01, a_r[22:0]};
                mb_r       <= {1'b1, b_r[22:0]};
                quo_r      <= '0;
                special_r  <= setup_special;
                spec_res_r <= is_zero(a_r) ? {a_r[31] ^ b_r[31], 31'd0}
                                           : (POS_INF | {a_r[31] ^ b_r[31], 31'd0});
                spec_dbz_r <= !is_zero(a_r) && is_zero(b_r);
            end
            ITER: begin
                rem_r <= rem_chain[BITS_PER_CYCLE];
                quo_r <= quo_chain[BITS_PER_CYCLE];
            end
            default: ;
        endcase
    end

    // Normalise the quotient so the leading one lands on the hidden bit.
    always_comb begin
        e_norm = ediff_r + (quo_r[26] ? E_BIAS : (E_BIAS - 10'sd1));
        mant   = quo_r[26] ? quo_r[25:3] : quo_r[24:2];
`ifdef FP_DIV_SEQ_ROUND_EN
        guard      = quo_r[26] ? quo_r[2] : quo_r[1];
        sticky     = (quo_r[26] ? |quo_r[1:0] : quo_r[0]) | (|rem_r);
        rnd        = round_rne(mant, guard, sticky);
        packed_res = range_pack(sign_r, e_norm + $signed({9'd0, rnd[23]}), rnd[22:0]);
`else
        packed_res = range_pack(sign_r, e_norm, mant);
`endif
    end

    // Iteration counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= '0;
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            if (state == SETUP)
                cnt_r <= CW'(ITER_CYCLES - 1);
            else if (state == ITER)
                cnt_r <= cnt_r - 1'b1;

            if (state == PACK) begin
                if (special_r) begin
                    result      <= spec_res_r;
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                    div_by_zero <= spec_dbz_r;
                end else begin
                    result      <= packed_res[31:0];
                    overflow    <= packed_res[33];
                    underflow   <= packed_res[32];
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Randomised and directed bench for fp_div_seq against an arithmetic reference model.
module tb_fp_div_seq;

    localparam int BPC = 1;
    localparam int LAT = 27 / BPC + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow, underflow, div_by_zero, busy;

    int total = 0;
    int bad   = 0;

    fp_div_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer quotient/remainder, then normalise, round, range-check.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] res, output logic [2:0] flags,
                                  output int lat);
        longint unsigned mx, my, num, q, r, mant;
        int  e;
        bit  g, st, s;
        s = x[31] ^ y[31];
        if (x[30:23] == 8'd0) begin
            res = {s, 31'd0}; flags = 3'b000; lat = 2;
        end else if (y[30:23] == 8'd0) begin
            res = {s, 8'hFF, 23'd0}; flags = 3'b001; lat = 2;
        end else begin
            lat = LAT;
            mx  = 64'(x[22:0]) + 64'h800000;
            my  = 64'(y[22:0]) + 64'h800000;
            num = mx << 26;
            q   = num / my;
            r   = num % my;
            if (q >= 64'h4000000) begin
                mant = (q >> 3) & 64'h7FFFFF;
                g    = ((q >> 2) & 1) != 0;
                st   = ((q & 3) != 0) || (r != 0);
                e    = int'(x[30:23]) - int'(y[30:23]) + 127;
            end else begin
                mant = (q >> 2) & 64'h7FFFFF;
                g    = ((q >> 1) & 1) != 0;
                st   = ((q & 1) != 0) || (r != 0);
                e    = int'(x[30:23]) - int'(y[30:23]) + 126;
            end
`ifdef FP_DIV_SEQ_ROUND_EN
            if (g && (st || (mant & 1) != 0)) mant = mant + 1;
            if (mant == 64'h800000) begin
                mant = 0;
                e    = e + 1;
            end
`endif
            if (e >= 255) begin
                res = {s, 8'hFF, 23'd0}; flags = 3'b100;
            end else if (e <= 0) begin
                res = {s, 31'd0}; flags = 3'b010;
            end else begin
                res = {s, 8'(e), 23'(mant)}; flags = 3'b000;
            end
        end
    endfunction

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input int stall, input bit poke, output logic [31:0] got);
        logic [31:0] er;
        logic [2:0]  ef;
        int          el, lat;
        model(x, y, er, ef, el);
        @(negedge clk);
        check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (poke) in_valid = (lat >= 2 && lat < 5);
        end
        in_valid = 1'b0;
        got = result;
        check({tag, "/latency"}, 32'(lat), 32'(el));
        check({tag, "/result"}, result, er);
        check({tag, "/flags"}, {29'd0, overflow, underflow, div_by_zero}, {29'd0, ef});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "/hold_result"}, result, er);
            check({tag, "/hold_flags"}, {29'd0, overflow, underflow, div_by_zero}, {29'd0, ef});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "/release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "/release_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, x, y;
        int mode;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/in_ready", 32'(in_ready), 32'd1);
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/result", result, 32'd0);
        check("reset/flags", {29'd0, overflow, underflow, div_by_zero}, 32'd0);
        rst = 1'b0;

        run_op("six_by_two", 32'h40C00000, 32'h40000000, 0, 1'b0, got);
        check("six_by_two/const", got, 32'h40400000);
        run_op("one_by_three", 32'h3F800000, 32'h40400000, 0, 1'b0, got);
`ifdef FP_DIV_SEQ_ROUND_EN
        check("one_by_three/const", got, 32'h3EAAAAAB);
`else
        check("one_by_three/const", got, 32'h3EAAAAAA);
`endif
        run_op("div_zero", 32'hC0000000, 32'h00000000, 0, 1'b0, got);
        check("div_zero/const", got, 32'hFF800000);
        run_op("zero_num", 32'h00000000, 32'h40000000, 0, 1'b0, got);
        check("zero_num/const", got, 32'h00000000);
        run_op("ovf", 32'h7F000000, 32'h00800000, 0, 1'b0, got);
        check("ovf/const", got, 32'h7F800000);
        run_op("unf", 32'h00800000, 32'h7F000000, 0, 1'b0, got);
        check("unf/const", got, 32'h00000000);
        run_op("stall_poke", 32'h40C00000, 32'h40000000, 10, 1'b1, got);

        // Abort mid-iteration
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort/out_valid", 32'(out_valid), 32'd0);
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/in_ready", 32'(in_ready), 32'd1);
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("abort/no_late_valid", 32'(out_valid), 32'd0);
        run_op("after_abort", 32'h40C00000, 32'h40000000, 0, 1'b0, got);
        check("after_abort/const", got, 32'h40400000);

        for (int n = 0; n < 60; n++) begin
            x = $urandom; y = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0: x[30:23] = 8'd0;
                1: y[30:23] = 8'd0;
                2: begin x[30:23] = 8'($urandom_range(200, 255)); y[30:23] = 8'($urandom_range(1, 80)); end
                3: begin x[30:23] = 8'($urandom_range(1, 80)); y[30:23] = 8'($urandom_range(200, 255)); end
                4: y[22:0] = 23'd0;
                default: ;
            endcase
            run_op("random", x, y, (n % 7 == 0) ? 2 : 0, 1'b0, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
Multi-cycle IEEE-754 single-precision divide controller for the FP ALU.
- Sequences a restoring mantissa division over several cycles instead of one unrolled combinational array.
- Computes sign, exponent and flags, and packs the result.
- Presents valid/ready handshakes on input and output so the ALU issue logic can stall on it.

Parameters:
BITS_PER_CYCLE, 1, quotient bits resolved per ITER cycle; legal values 1, 3, 9, 27; illegal value is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  32  dividend, IEEE-754 single
b  input  32  divisor, IEEE-754 single
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  32  quotient, IEEE-754 single
overflow  output  1  exponent overflow; result is signed infinity
underflow  output  1  exponent underflow; result is signed zero
div_by_zero  output  1  b is zero and a is nonzero
busy  output  1  state is not IDLE

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, all flags=0, state=IDLE.
- rst mid-operation aborts the operation, discards it, and returns to IDLE on the next edge.
- States and transitions:
  - IDLE: stays here until in_valid&in_ready, then latches a and b and goes to SETUP.
  - SETUP (1 cycle): unpacks operands, handles special cases, then goes to ITER or straight to PACK.
  - ITER (27/BITS_PER_CYCLE cycles): iteration counter counts down, then goes to PACK.
  - PACK (1 cycle): normalises, packs, then goes to DONE.
  - DONE: holds out_valid until out_ready, then goes to IDLE.
- Latency:
  - out_valid rises exactly 27/BITS_PER_CYCLE+2 edges after the accepting edge (29 for default).
  - Special cases take 2 edges.
- Outputs stay stable while out_valid=1 and out_ready=0.
- No new operand is accepted in the same cycle a result leaves; one op in flight.
- Unpack:
  - sign = a[31]^b[31].
  - Exponent field 0 means the operand is zero; denormals are flushed to zero.
  - ma = {1,a[22:0]}, mb = {1,b[22:0]}.
- Special cases (decided in SETUP, skip ITER):
  - a zero gives {sign,31'b0} with no flags.
  - Else b zero gives {sign,8'hFF,23'b0} with div_by_zero=1.
  - Exponent field 255 inputs are not special-cased; they are treated as ordinary numbers.
- Division:
  - Computes Q = floor((ma<<26)/mb), 27 bits, with 27-bit remainder R, by restoring division, MSB first.
  - Each step shifts the remainder, trial-subtracts mb, keeps the result if non-negative, and shifts the quotient bit in.
- Normalise:
  - If Q[26]=1: mant=Q[25:3], guard=Q[2], sticky=|Q[1:0] or R!=0, e=ea-eb+127.
  - Else: mant=Q[24:2], guard=Q[1], sticky=Q[0] or R!=0, e=ea-eb+126.
  - e is a 10-bit signed intermediate.
- Range:
  - e>=255 gives overflow=1 and result {sign,8'hFF,23'b0}.
  - e<=0 gives underflow=1 and result {sign,31'b0}.
  - Otherwise result = {sign,e[7:0],mant}.
- Default rounding is truncation.

Optional Feature:
FP_DIV_SEQ_ROUND_EN
- Defined: round-to-nearest-even in PACK.
  - Increment mant if guard & (sticky | mant[0]).
  - Mantissa carry-out sets mant=0 and e=e+1, then the range check runs on the new e.
  - Latency is unchanged.
- Undefined: truncation; guard and sticky are ignored.

Decomposition:
- Shared package fp_div_pkg holds:
  - state enum (IDLE, SETUP, ITER, PACK, DONE)
  - EXP_BIAS=127, QBITS=27, EXP_MAX=255
  - POS_INF=32'h7F800000
  - a zero-test function
- Sub-module fp_div_step: combinational single restoring step taking remainder, divisor and quotient; instantiated BITS_PER_CYCLE times as a chain inside ITER.

Test Plan:
- a=0x40C00000, b=0x40000000 -> result 0x40400000, no flags, out_valid exactly 29 edges after accept (BITS_PER_CYCLE=1); 11 edges with BITS_PER_CYCLE=3.
- a=0x3F800000, b=0x40400000 -> 0x3EAAAAAA without the macro; 0x3EAAAAAB with FP_DIV_SEQ_ROUND_EN.
- a=0xC0000000, b=0x00000000 -> 0xFF800000, div_by_zero=1, out_valid 2 edges after accept; a=0 with b=0x40000000 -> 0x00000000, no flags.
- a=0x7F000000, b=0x00800000 -> 0x7F800000, overflow=1; swapped operands -> 0x00000000, underflow=1.
- out_ready held low 10 cycles after out_valid -> result and flags stable, in_ready=0; in_valid pulses during ITER are ignored; out_ready=1 -> IDLE next edge, in_ready=1.
- rst asserted for 1 cycle mid-ITER -> next edge IDLE, out_valid=0, busy=0; a following op 0x40C00000/0x40000000 completes correctly.
